// File: rtl/rc6_serial_rx_if.sv
// Block handshake between the serial receiver and the RC6 round core.
// The receiver drives the assembled block and its valid flag; the core answers with ready.
interface rc6_serial_rx_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/rc6_serial_rx.sv
// Serial-to-parallel front end for the RC6 core: synchronises the external bit link,
// assembles one DATA_W-bit block per frame and holds it until the core accepts it.
module rc6_serial_rx #(
    parameter int DATA_W      = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_in,
    input  logic           sta_in,
    input  logic           data_in,
    rc6_serial_rx_if.master rx,
    output logic           busy,
    output logic           overrun
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] sta_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_in_q;
    logic                   bit_stb;
    logic                   sta_s;
    logic                   data_s;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       cnt;

    // The strobe is registered together with its data/start samples so all three
    // reach the FSM in the same cycle, SYNC_STAGES+2 clocks after the clk_in edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync  <= '0;
            sta_sync  <= '0;
            data_sync <= '0;
            clk_in_q  <= 1'b0;
            bit_stb   <= 1'b0;
            sta_s     <= 1'b0;
            data_s    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            sta_sync  <= {sta_sync[SYNC_STAGES-2:0], sta_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
            clk_in_q  <= clk_sync[SYNC_STAGES-1];
            bit_stb   <= clk_sync[SYNC_STAGES-1] & ~clk_in_q;
            sta_s     <= sta_sync[SYNC_STAGES-1];
            data_s    <= data_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_stb && sta_s) begin
                        shreg <= {shreg[DATA_W-2:0], data_s};
                        cnt   <= ONE;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_stb) begin
                        // A start marker mid-frame restarts assembly from this bit.
                        if (sta_s) begin
                            shreg <= {{(DATA_W-1){1'b0}}, data_s};
                            cnt   <= ONE;
                        end else if (cnt == LAST_BIT) begin
                            rx.data_out   <= {shreg[DATA_W-2:0], data_s};
                            rx.data_valid <= 1'b1;
                            cnt           <= '0;
                            state         <= HOLD;
                            busy          <= 1'b0;
                        end else begin
                            shreg <= {shreg[DATA_W-2:0], data_s};
                            cnt   <= cnt + ONE;
                        end
                    end
                end
                HOLD: begin
                    if (bit_stb && sta_s) begin
                        overrun <= 1'b1;
                    end
                    if (rx.data_ready) begin
                        rx.data_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc6_serial_rx.sv
// Self-checking bench for rc6_serial_rx: random frames on the serial link compared
// against a bit-queue model of frame assembly.
module tb_rc6_serial_rx;

    localparam int DATA_W = 128;
    localparam int SYNC   = 2;

    logic clk;
    logic reset;
    logic clk_in;
    logic sta_in;
    logic data_in;
    logic busy;
    logic overrun;

    rc6_serial_rx_if #(.DATA_W(DATA_W)) bus ();

    rc6_serial_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_in  (clk_in),
        .sta_in  (sta_in),
        .data_in (data_in),
        .rx      (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              mdl_bits[$];
    bit                mdl_on = 0;
    int                overrun_cycles = 0;
    int                valid_cycles = 0;
    logic              prev_valid = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    // Monitor: records each completed block and counts valid/overrun cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1 && prev_valid !== 1'b1) got_q.push_back(bus.data_out);
            if (bus.data_valid === 1'b1) valid_cycles++;
            if (overrun === 1'b1) overrun_cycles++;
            prev_valid = bus.data_valid;
        end
    end

    task automatic clear_monitor();
        @(posedge clk);
        got_q.delete();
        exp_q.delete();
        overrun_cycles = 0;
        valid_cycles = 0;
    endtask

    // Reference: a frame is the DATA_W bits following the latest start marker.
    task automatic model_bit(input logic s, input logic d);
        logic [DATA_W-1:0] v;
        if (s) begin
            mdl_bits.delete();
            mdl_on = 1;
        end
        if (mdl_on) begin
            mdl_bits.push_back(d);
            if (mdl_bits.size() == DATA_W) begin
                for (int i = 0; i < DATA_W; i++) v[DATA_W-1-i] = mdl_bits[i];
                exp_q.push_back(v);
                mdl_on = 0;
            end
        end
    endtask

    task automatic send_bit(input logic s, input logic d);
        model_bit(s, d);
        @(negedge clk);
        sta_in  = s;
        data_in = d;
        clk_in  = 1'b0;
        repeat (4) @(negedge clk);
        clk_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(i == 0, v[DATA_W-1-i]);
    endtask

    function automatic logic [DATA_W-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        int bad = 0;
        reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.data_out !== '0 || bus.data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0)
                bad++;
            clk_in  = 1'($urandom_range(0, 1));
            sta_in  = 1'($urandom_range(0, 1));
            data_in = 1'($urandom_range(0, 1));
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL reset_outputs bad_cycles=%0d required 0", bad);
        end
        clk_in = 0; sta_in = 0; data_in = 0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.data_out !== '0 || bus.data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release out=%h valid=%b busy=%b required 0/0/0",
                     bus.data_out, bus.data_valid, busy);
        end
    endtask

    task automatic test_single_block();
        logic [DATA_W-1:0] v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        clear_monitor();
        bus.data_ready = 1'b1;
        for (int i = 0; i < DATA_W-1; i++) send_bit(i == 0, v[DATA_W-1-i]);
        model_bit(1'b0, v[0]);
        @(negedge clk);
        sta_in = 1'b0; data_in = v[0]; clk_in = 1'b0;
        repeat (4) @(negedge clk);
        clk_in = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early valid=%b required 0", bus.data_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_on_time valid=%b required 1", bus.data_valid);
        end
        checks++;
        if (bus.data_out !== v) begin
            errors++;
            $display("[TB] FAIL single_data got=%h required %h", bus.data_out, v);
        end
        checks++;
        if (bus.data_out[31:0] !== 32'h7654_3210) begin
            errors++;
            $display("[TB] FAIL word_a got=%h required 76543210", bus.data_out[31:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_one_cycle valid=%b required 0", bus.data_valid);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (valid_cycles !== 1 || got_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL single_count valid_cycles=%0d blocks=%0d required 1/%0d",
                     valid_cycles, got_q.size(), exp_q.size());
        end
        checks++;
        if (overrun_cycles !== 0) begin
            errors++;
            $display("[TB] FAIL single_overrun cycles=%0d required 0", overrun_cycles);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] v = rand_block();
        int bad = 0;
        clear_monitor();
        bus.data_ready = 1'b0;
        send_frame(v, DATA_W);
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || bus.data_out !== v) begin
            errors++;
            $display("[TB] FAIL bp_capture blocks=%0d got=%h required 1 %h", got_q.size(), bus.data_out, v);
        end
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.data_out !== v || bus.data_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL bp_hold bad_cycles=%0d required 0", bad);
        end
        send_frame(rand_block(), 10);
        repeat (10) @(negedge clk);
        checks++;
        if (overrun_cycles !== 1) begin
            errors++;
            $display("[TB] FAIL bp_overrun cycles=%0d required 1", overrun_cycles);
        end
        checks++;
        if (bus.data_out !== v || bus.data_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_dropped out=%h valid=%b busy=%b required %h/1/0",
                     bus.data_out, bus.data_valid, busy, v);
        end
        bus.data_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b0 || busy !== 1'b0 || bus.data_out !== v) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%b busy=%b out=%h required 0/0/%h",
                     bus.data_valid, busy, bus.data_out, v);
        end
        send_frame(rand_block(), DATA_W);
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 2 || exp_q.size() !== 2 || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("[TB] FAIL bp_next_frame blocks=%0d required 2", got_q.size());
        end
    endtask

    task automatic test_resync();
        logic [DATA_W-1:0] ones = '1;
        clear_monitor();
        bus.data_ready = 1'b1;
        send_frame(rand_block(), 40);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resync_busy busy=%b required 1", busy);
        end
        send_frame(ones, DATA_W);
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || exp_q.size() !== 1 || got_q[0] !== exp_q[0] || got_q[0] !== ones) begin
            errors++;
            $display("[TB] FAIL resync_data blocks=%0d got=%h required 1 %h", got_q.size(), bus.data_out, ones);
        end
        checks++;
        if (overrun_cycles !== 0) begin
            errors++;
            $display("[TB] FAIL resync_overrun cycles=%0d required 0", overrun_cycles);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] a5 = {16{8'hA5}};
        clear_monitor();
        send_frame(rand_block(), 64);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mdl_on = 0;
        mdl_bits.delete();
        checks++;
        if (busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_clear busy=%b valid=%b out=%h required 0/0/0",
                     busy, bus.data_valid, bus.data_out);
        end
        send_frame(a5, DATA_W);
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== a5 || exp_q.size() !== 1 || exp_q[0] !== got_q[0]) begin
            errors++;
            $display("[TB] FAIL midreset_data blocks=%0d got=%h required 1 %h", got_q.size(), bus.data_out, a5);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        clear_monitor();
        bus.data_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(rand_block(), DATA_W);
            repeat (8) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 3 || exp_q.size() !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_count blocks=%0d required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("[TB] FAIL b2b_data wrong_blocks=%0d required 0", bad);
            end
        end
        checks++;
        if (overrun_cycles !== 0 || valid_cycles !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_flags overrun=%0d valid_cycles=%0d required 0/3",
                     overrun_cycles, valid_cycles);
        end
    endtask

    initial begin
        reset = 1'b0;
        clk_in = 0; sta_in = 0; data_in = 0;
        bus.data_ready = 1'b0;
        test_reset();
        test_single_block();
        test_backpressure();
        test_resync();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
